operand_bram: RTL and testbench
===============================

OPERAND_BRAM -- requirements
Module: operand_bram

Interface
REQ-001 SHALL have parameter s, default 16, meaning operand size in 17-bit blocks.
REQ-002 SHALL have localparam DEPTH = 4*s, meaning word count; ADDR_W = $clog2(4*s), meaning address width.
REQ-003 SHALL have port clock_i  in  1  meaning the single clock.
REQ-004 SHALL have port reset_i  in  1  meaning reset, synchronous and active-high.
REQ-005 SHALL have core-side ports:
- BRAM_en_i  in  1  core access enable
- BRAM_we_i  in  1  core write enable
- BRAM_addr_i  in  ADDR_W  core word address
- BRAM_din_i  in  17  core write data
- BRAM_dout_o  out  32  core read data
REQ-006 SHALL have host control ports:
- host_start_i  in  1  start pulse
- host_mode_i  in  1  0 = load operands, 1 = read back result
- host_busy_o  out  1  operation in progress
- host_done_o  out  1  one-cycle completion pulse
REQ-007 SHALL have host write channel ports host_wdata_i in 32, host_wvalid_i in 1, host_wready_o out 1: load stream.
REQ-008 SHALL have host read channel ports host_rdata_o out 32, host_rvalid_o out 1, host_rready_i in 1: result stream.

Function
REQ-009 SHALL hold one single-port array of DEPTH 32-bit words with one access per cycle.
REQ-010 SHALL use this memory map: n at 0..s-1, n_prime_0 at s, X at s+1..2s, Y at 2s+1..3s, result at 0..s-1.
REQ-011 Core reads SHALL have a fixed 2-cycle latency: addr at cycle t gives BRAM_dout_o valid at t+2 (array register plus output register).
REQ-012 BRAM_dout_o SHALL hold its last value when no core read occurs.
REQ-013 Core writes SHALL store {15'd0, BRAM_din_i}.
REQ-014 Core access SHALL always win arbitration. In any cycle with BRAM_en_i=1, host_wready_o SHALL be 0 and no host read SHALL be issued.
REQ-015 FSM states SHALL be IDLE, LOAD, READ, DONE.
REQ-016 In IDLE, host_start_i SHALL go to LOAD (mode 0) or READ (mode 1) and clear the word counter.
REQ-017 host_start_i SHALL be ignored outside IDLE.
REQ-018 In LOAD:
- host_wready_o = !BRAM_en_i.
- Each wvalid&wready handshake writes host_wdata_i to address = counter, then increments the counter.
- After 3*s+1 accepted words, the FSM SHALL go to DONE.
REQ-019 In READ:
- Reads of addresses 0..s-1 are issued in order into a 4-entry output FIFO.
- A read is issued only when !BRAM_en_i and (outstanding + FIFO occupancy) < 4.
- No word SHALL be dropped or reordered under any host_rready_i pattern.
REQ-020 host_rvalid_o SHALL equal FIFO not-empty, and host_rdata_o SHALL be the FIFO head.
REQ-021 READ SHALL go to DONE after the s-th rvalid&rready handshake.
REQ-022 In DONE, host_done_o = 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 host_busy_o SHALL be 1 in LOAD and READ, else 0.
REQ-024 A FIFO push and pop in the same cycle SHALL keep occupancy unchanged.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE and counters, outstanding count and FIFO SHALL be cleared.
REQ-026 On reset, BRAM_dout_o, host_rdata_o, host_rvalid_o, host_wready_o, host_busy_o and host_done_o SHALL be 0.
REQ-027 Array contents SHALL NOT be reset.
REQ-028 Reset mid-LOAD or mid-READ SHALL abort with no done pulse; in-flight reads SHALL be discarded.

Structure
REQ-029 The FSM state enum and the map offsets (N_BASE=0, NP0_ADDR=s, X_BASE=s+1, Y_BASE=2s+1) SHALL live in shared package fios_pkg.
REQ-030 The output FIFO SHALL be one sub-module, sync_fifo, with parameters WIDTH=32 and DEPTH=4.

Verification (s=16)
REQ-031 Load 49 words, value 0x100+i; core read of addr 17 -> BRAM_dout_o = 0x111 exactly 2 cycles later; one host_done_o pulse.
REQ-032 During LOAD, hold BRAM_en_i=1 for 3 cycles -> host_wready_o=0 for those cycles; all 49 words land at correct addresses.
REQ-033 Core writes 0x1FFFF to addr 3, then READ -> host word 3 = 0x0001FFFF, words 0..15 in order.
REQ-034 During READ, host_rready_i=0 for 10 cycles -> never more than 4 reads in flight or buffered; no loss; done after the 16th handshake.
REQ-035 Assert reset_i at LOAD word 20 -> next cycle host_busy_o=0 with no done pulse; a new host_start_i is accepted normally.
REQ-036 host_start_i during READ -> ignored; mode and counter unchanged.

Source files
------------

// File: rtl/fios_pkg.sv
// Shared definitions for the FIOS operand memory: controller states and
// the operand/result memory map.
package fios_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_READ = 2'd2,
      ST_DONE = 2'd3
   } fios_state_e;

   localparam int FIOS_S         = 16;
   localparam int N_BASE         = 0;
   localparam int NP0_ADDR       = FIOS_S;
   localparam int X_BASE         = FIOS_S + 1;
   localparam int Y_BASE         = 2 * FIOS_S + 1;
   localparam int OUT_FIFO_DEPTH = 4;

   // Map offsets for an arbitrary operand size s
   function automatic int np0_addr_f(input int s);
      return s;
   endfunction

   function automatic int x_base_f(input int s);
      return s + 1;
   endfunction

   function automatic int y_base_f(input int s);
      return 2 * s + 1;
   endfunction

   // n, n_prime_0, X and Y are streamed in as one contiguous block
   function automatic int load_words_f(input int s);
      return y_base_f(s) + s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; head word is visible whenever the FIFO is not empty.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head,
   output logic                         empty,
   output logic                         full,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] store_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [OCC_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return {PTR_W{1'b0}};
      end else begin
         return p + PTR_W'(1);
      end
   endfunction

   // Qualify requests against current occupancy
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (push && (count_r != OCC_W'(DEPTH))) begin
         do_push_s = 1'b1;
      end else begin
         do_push_s = 1'b0;
      end
      if (pop && (count_r != {OCC_W{1'b0}})) begin
         do_pop_s = 1'b1;
      end else begin
         do_pop_s = 1'b0;
      end
   end

   // Storage, pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            store_r[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {OCC_W{1'b0}};
      end else begin
         if (do_push_s) begin
            store_r[wr_ptr_r] <= push_data;
            wr_ptr_r          <= ptr_inc(wr_ptr_r);
         end
         if (do_pop_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + OCC_W'(1);
            2'b01:   count_r <= count_r - OCC_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head  = store_r[rd_ptr_r];
   assign empty = (count_r == {OCC_W{1'b0}});
   assign full  = (count_r == OCC_W'(DEPTH));
   assign count = count_r;

endmodule

// File: rtl/operand_bram.sv
// Single-port operand/result memory shared by the Montgomery core and a host
// streaming loader/unloader; the core always wins the port.
module operand_bram
   import fios_pkg::*;
#(
   parameter int s = 16
) (
   input  logic                       clock_i,
   input  logic                       reset_i,
   input  logic                       BRAM_en_i,
   input  logic                       BRAM_we_i,
   input  logic [$clog2(4*s)-1:0]     BRAM_addr_i,
   input  logic [16:0]                BRAM_din_i,
   output logic [31:0]                BRAM_dout_o,
   input  logic                       host_start_i,
   input  logic                       host_mode_i,
   output logic                       host_busy_o,
   output logic                       host_done_o,
   input  logic [31:0]                host_wdata_i,
   input  logic                       host_wvalid_i,
   output logic                       host_wready_o,
   output logic [31:0]                host_rdata_o,
   output logic                       host_rvalid_o,
   input  logic                       host_rready_i
);

   localparam int DEPTH      = 4 * s;
   localparam int ADDR_W     = $clog2(4 * s);
   localparam int CNT_W      = ADDR_W + 1;
   localparam int OCC_W      = $clog2(OUT_FIFO_DEPTH + 1);
   localparam int OCC_W1     = OCC_W + 1;
   localparam int LOAD_WORDS = load_words_f(s);

   localparam logic [CNT_W-1:0]  LOAD_LAST  = CNT_W'(N_BASE + LOAD_WORDS - 1);
   localparam logic [CNT_W-1:0]  RES_WORDS  = CNT_W'(s);
   localparam logic [CNT_W-1:0]  RES_LAST   = CNT_W'(s - 1);
   localparam logic [OCC_W1-1:0] FIFO_LIMIT = OCC_W1'(OUT_FIFO_DEPTH);

   fios_state_e       state_r;
   fios_state_e       state_nx_s;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  hs_cnt_r;
   logic [31:0]       mem_r [DEPTH];
   logic [31:0]       rd_q_r;
   logic [31:0]       dout_r;
   logic              core_rd_v_r;
   logic              host_rd_v_r;
   logic [OCC_W-1:0]  outst_r;
   logic [OCC_W-1:0]  fifo_count_s;
   logic [OCC_W1-1:0] inflight_s;
   logic [31:0]       fifo_head_s;
   logic              fifo_empty_s;
   logic              fifo_full_s;
   logic              wready_s;
   logic              host_wr_s;
   logic              host_rd_s;
   logic              core_rd_s;
   logic              pop_s;
   logic [ADDR_W-1:0] acc_addr_s;
   logic              acc_we_s;
   logic [31:0]       acc_wdata_s;

   // Port arbitration and host handshakes
   always_comb begin
      wready_s    = 1'b0;
      host_wr_s   = 1'b0;
      host_rd_s   = 1'b0;
      core_rd_s   = 1'b0;
      pop_s       = 1'b0;
      acc_addr_s  = {ADDR_W{1'b0}};
      acc_we_s    = 1'b0;
      acc_wdata_s = 32'd0;
      inflight_s  = {1'b0, outst_r} + {1'b0, fifo_count_s};

      if (state_r == ST_LOAD) begin
         wready_s = !BRAM_en_i;
      end else begin
         wready_s = 1'b0;
      end
      host_wr_s = wready_s && host_wvalid_i;

      // Reads are only issued when a FIFO slot is guaranteed for the data
      if ((state_r == ST_READ) && !BRAM_en_i && (cnt_r < RES_WORDS) &&
          (inflight_s < FIFO_LIMIT) && !fifo_full_s) begin
         host_rd_s = 1'b1;
      end else begin
         host_rd_s = 1'b0;
      end

      core_rd_s = BRAM_en_i && !BRAM_we_i;
      pop_s     = !fifo_empty_s && host_rready_i;

      if (BRAM_en_i) begin
         acc_addr_s  = BRAM_addr_i;
         acc_we_s    = BRAM_we_i;
         acc_wdata_s = {15'd0, BRAM_din_i};
      end else begin
         acc_addr_s  = cnt_r[ADDR_W-1:0] + ADDR_W'(N_BASE);
         acc_we_s    = host_wr_s;
         acc_wdata_s = host_wdata_i;
      end
   end

   // Memory array and its read register; contents survive reset
   always_ff @(posedge clock_i) begin
      if (acc_we_s) begin
         mem_r[acc_addr_s] <= acc_wdata_s;
      end else if (core_rd_s || host_rd_s) begin
         rd_q_r <= mem_r[acc_addr_s];
      end
   end

   // Read pipeline tags, core output register and in-flight host reads
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         core_rd_v_r <= 1'b0;
         host_rd_v_r <= 1'b0;
         dout_r      <= 32'd0;
         outst_r     <= {OCC_W{1'b0}};
      end else begin
         core_rd_v_r <= core_rd_s;
         host_rd_v_r <= host_rd_s;
         if (core_rd_v_r) begin
            dout_r <= rd_q_r;
         end
         case ({host_rd_s, host_rd_v_r})
            2'b10:   outst_r <= outst_r + OCC_W'(1);
            2'b01:   outst_r <= outst_r - OCC_W'(1);
            default: outst_r <= outst_r;
         endcase
      end
   end

   // Controller state and word counters
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_r  <= ST_IDLE;
         cnt_r    <= {CNT_W{1'b0}};
         hs_cnt_r <= {CNT_W{1'b0}};
      end else begin
         state_r <= state_nx_s;
         case (state_r)
            ST_IDLE: begin
               if (host_start_i) begin
                  cnt_r    <= {CNT_W{1'b0}};
                  hs_cnt_r <= {CNT_W{1'b0}};
               end
            end
            ST_LOAD: begin
               if (host_wr_s) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            ST_READ: begin
               if (host_rd_s) begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
               if (pop_s) begin
                  hs_cnt_r <= hs_cnt_r + CNT_W'(1);
               end
            end
            default: begin
               cnt_r    <= cnt_r;
               hs_cnt_r <= hs_cnt_r;
            end
         endcase
      end
   end

   // Next-state decode
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (host_start_i) begin
               state_nx_s = host_mode_i ? ST_READ : ST_LOAD;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (host_wr_s && (cnt_r == LOAD_LAST)) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_LOAD;
            end
         end
         ST_READ: begin
            if (pop_s && (hs_cnt_r == RES_LAST)) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_READ;
            end
         end
         ST_DONE: state_nx_s = ST_IDLE;
         default: state_nx_s = ST_IDLE;
      endcase
   end

   sync_fifo #(
      .WIDTH (32),
      .DEPTH (OUT_FIFO_DEPTH)
   ) u_out_fifo (
      .clk       (clock_i),
      .rst       (reset_i),
      .push      (host_rd_v_r),
      .push_data (rd_q_r),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .empty     (fifo_empty_s),
      .full      (fifo_full_s),
      .count     (fifo_count_s)
   );

   assign BRAM_dout_o   = dout_r;
   assign host_wready_o = wready_s;
   assign host_rvalid_o = !fifo_empty_s;
   assign host_rdata_o  = fifo_head_s;
   assign host_busy_o   = (state_r == ST_LOAD) || (state_r == ST_READ);
   assign host_done_o   = (state_r == ST_DONE);

endmodule

// File: tb/tb_operand_bram.sv
// Randomized bench for operand_bram against a word-level model of memory,
// host phases and the two-cycle core read path.
module tb_operand_bram;

   localparam int S     = 16;
   localparam int AW    = $clog2(4 * S);
   localparam int NLOAD = 3 * S + 1;

   logic          clock_i = 1'b0;
   logic          reset_i;
   logic          BRAM_en_i;
   logic          BRAM_we_i;
   logic [AW-1:0] BRAM_addr_i;
   logic [16:0]   BRAM_din_i;
   logic [31:0]   BRAM_dout_o;
   logic          host_start_i;
   logic          host_mode_i;
   logic          host_busy_o;
   logic          host_done_o;
   logic [31:0]   host_wdata_i;
   logic          host_wvalid_i;
   logic          host_wready_o;
   logic [31:0]   host_rdata_o;
   logic          host_rvalid_o;
   logic          host_rready_i;

   operand_bram #(.s(S)) dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .BRAM_en_i     (BRAM_en_i),
      .BRAM_we_i     (BRAM_we_i),
      .BRAM_addr_i   (BRAM_addr_i),
      .BRAM_din_i    (BRAM_din_i),
      .BRAM_dout_o   (BRAM_dout_o),
      .host_start_i  (host_start_i),
      .host_mode_i   (host_mode_i),
      .host_busy_o   (host_busy_o),
      .host_done_o   (host_done_o),
      .host_wdata_i  (host_wdata_i),
      .host_wvalid_i (host_wvalid_i),
      .host_wready_o (host_wready_o),
      .host_rdata_o  (host_rdata_o),
      .host_rvalid_o (host_rvalid_o),
      .host_rready_i (host_rready_i)
   );

   always #5 clock_i = ~clock_i;

   int checks = 0;
   int errors = 0;

   // stimulus for the next cycle
   logic          d_rst = 1'b1, d_en = 1'b0, d_we = 1'b0, d_start = 1'b0, d_mode = 1'b0;
   logic          d_wvalid = 1'b0, d_rready = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [16:0]   d_din = '0;
   logic [31:0]   d_wdata = '0;

   // reference model: 0 idle, 1 load, 2 read, 3 done
   logic [31:0] mem_m [4*S];
   logic [31:0] exp_q [S];
   logic [31:0] rx_q  [S];
   int          m_phase = 0;
   int          m_cnt   = 0;
   int          done_cnt = 0;
   logic        q0_v = 1'b0, q1_v = 1'b0;
   logic [31:0] q0_d = '0, q1_d = '0, dout_exp = '0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      logic hs;
      @(negedge clock_i);
      reset_i       = d_rst;
      BRAM_en_i     = d_en;
      BRAM_we_i     = d_we;
      BRAM_addr_i   = d_addr;
      BRAM_din_i    = d_din;
      host_start_i  = d_start;
      host_mode_i   = d_mode;
      host_wdata_i  = d_wdata;
      host_wvalid_i = d_wvalid;
      host_rready_i = d_rready;
      #1;
      if (q1_v) dout_exp = q1_d;
      check_val("dout", BRAM_dout_o, dout_exp);
      check_val("busy", 32'(host_busy_o), 32'(m_phase == 1 || m_phase == 2));
      check_val("done", 32'(host_done_o), 32'(m_phase == 3));
      check_val("wready", 32'(host_wready_o), 32'(m_phase == 1 && !d_en));
      if (m_phase != 2) check_val("rvalid_idle", 32'(host_rvalid_o), 32'd0);
      hs = (m_phase == 2) && host_rvalid_o && d_rready;
      if (hs) begin
         check_val("rdata", host_rdata_o, exp_q[m_cnt]);
         rx_q[m_cnt] = host_rdata_o;
      end
      if (host_done_o) done_cnt++;
      if (d_rst) begin
         m_phase = 0; m_cnt = 0; q0_v = 1'b0; q1_v = 1'b0; dout_exp = 32'd0;
      end else begin
         q1_v = q0_v; q1_d = q0_d;
         q0_v = d_en && !d_we;
         if (q0_v) q0_d = mem_m[d_addr];
         if (d_en && d_we) mem_m[d_addr] = {15'd0, d_din};
         case (m_phase)
            0: if (d_start) begin
                  m_phase = d_mode ? 2 : 1;
                  m_cnt   = 0;
                  if (d_mode) for (int i = 0; i < S; i++) exp_q[i] = mem_m[i];
               end
            1: if (d_wvalid && !d_en) begin
                  mem_m[m_cnt] = d_wdata;
                  m_cnt++;
                  if (m_cnt == NLOAD) m_phase = 3;
               end
            2: if (hs) begin
                  m_cnt++;
                  if (m_cnt == S) m_phase = 3;
               end
            default: m_phase = 0;
         endcase
      end
   endtask

   task automatic idle_inputs();
      d_rst = 1'b0; d_en = 1'b0; d_we = 1'b0; d_start = 1'b0;
      d_wvalid = 1'b0; d_rready = 1'b0;
   endtask

   // stream one operand load; rst_at >= 0 aborts when that many words are in
   task automatic run_load(input logic [31:0] base, input int rst_at);
      int win = 0;
      bit win_done = 1'b0;
      idle_inputs();
      d_start = 1'b1; d_mode = 1'b0;
      step();
      d_start = 1'b0;
      for (int n = 0; n < 600 && m_phase != 0; n++) begin
         if (m_cnt == rst_at) begin
            idle_inputs();
            d_rst = 1'b1;
            step();
            d_rst = 1'b0;
            return;
         end
         if (!win_done && m_cnt >= 8) begin
            win = 3; win_done = 1'b1;
         end
         if (win > 0) begin
            d_en = 1'b1; d_we = 1'b0;
            d_addr = AW'($urandom_range(0, m_cnt - 1));
            win--;
         end else begin
            d_en = 1'b0;
         end
         d_wvalid = ($urandom % 4) != 0;
         d_wdata  = base + 32'(m_cnt);
         step();
      end
      check_val("load_timeout_phase", 32'(m_phase), 32'd0);
      idle_inputs();
   endtask

   // unload the result with a stalled window, core reads and a stray start
   task automatic run_read(input int rst_at);
      idle_inputs();
      d_start = 1'b1; d_mode = 1'b1;
      step();
      d_start = 1'b0;
      for (int n = 0; n < 800 && m_phase != 0; n++) begin
         if (n == rst_at) begin
            idle_inputs();
            d_rst = 1'b1;
            step();
            d_rst = 1'b0;
            return;
         end
         d_start  = (n == 5);
         d_mode   = 1'b0;
         d_rready = (n >= 3 && n < 13) ? 1'b0 : (($urandom % 4) != 0);
         d_en     = ($urandom % 5) == 0;
         d_we     = 1'b0;
         d_addr   = AW'($urandom_range(0, NLOAD - 1));
         step();
      end
      check_val("read_timeout_phase", 32'(m_phase), 32'd0);
      idle_inputs();
   endtask

   initial begin
      reset_i = 1'b1; BRAM_en_i = 1'b0; BRAM_we_i = 1'b0; BRAM_addr_i = '0;
      BRAM_din_i = '0; host_start_i = 1'b0; host_mode_i = 1'b0; host_wdata_i = '0;
      host_wvalid_i = 1'b0; host_rready_i = 1'b0;
      repeat (2) @(posedge clock_i);
      d_rst = 1'b1;
      step();
      check_val("rst_rdata", host_rdata_o, 32'd0);
      check_val("rst_rvalid", 32'(host_rvalid_o), 32'd0);
      check_val("rst_dout", BRAM_dout_o, 32'd0);
      idle_inputs();
      step();

      run_load(32'h100, -1);
      check_val("load1_done_cnt", 32'(done_cnt), 32'd1);

      d_en = 1'b1; d_we = 1'b0; d_addr = AW'(17);
      step();
      d_en = 1'b0;
      step();
      step();
      check_val("dout_addr17", BRAM_dout_o, 32'h111);

      for (int i = 0; i < 30; i++) begin
         d_en = ($urandom % 2) != 0; d_we = 1'b0;
         d_addr = AW'($urandom_range(0, NLOAD - 1));
         step();
      end
      d_en = 1'b1; d_we = 1'b1; d_addr = AW'(3); d_din = 17'h1FFFF;
      step();
      for (int i = 8; i < 12; i++) begin
         d_addr = AW'(i); d_din = 17'($urandom);
         step();
      end
      idle_inputs();
      step();

      run_read(-1);
      check_val("read1_done_cnt", 32'(done_cnt), 32'd2);
      check_val("host_word3", rx_q[3], 32'h0001FFFF);

      run_load(32'h200, 20);
      step();
      check_val("abort_busy", 32'(host_busy_o), 32'd0);
      check_val("abort_no_done", 32'(done_cnt), 32'd2);

      run_load(32'h200, -1);
      check_val("load2_done_cnt", 32'(done_cnt), 32'd3);

      run_read(6);
      repeat (4) step();
      check_val("rd_abort_no_done", 32'(done_cnt), 32'd3);

      run_read(-1);
      check_val("read2_done_cnt", 32'(done_cnt), 32'd4);
      check_val("res_word0", rx_q[0], 32'h200);
      check_val("res_word15", rx_q[15], 32'h20F);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
